// File: rtl/miriscv_lsu.sv
// miriscv_lsu -- load/store unit between the core datapath and the data RAM port.
//
// Turns one core load/store request into a req/gnt/rvalid transaction, stalls
// the core until the response returns, builds byte enables and lane-replicated
// write data, and extracts and sign/zero-extends load data.
//
// Handshake: data_req_o stays high with stable we/be/addr/wdata until a cycle
// with data_gnt_i=1 (the grant cycle); exactly one data_rvalid_i follows each
// grant. rvalid seen while no granted request is outstanding is dropped.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   lsu_req_i/we_i        core request, 1 = store
//   lsu_size_i            funct3 access size (LB/LH/LW/LBU/LHU encodings)
//   lsu_addr_i            byte address
//   lsu_data_i            store data (low byte/half/word used)
//   lsu_data_o            extended load result (held between loads)
//   lsu_stall_o           core must hold its state
//   lsu_err_o             misaligned or illegal size, no memory access
//   data_req_o..wdata_o   request side of the memory port
//   data_gnt_i            memory accepted the request
//   data_rvalid_i/rdata_i response side of the memory port
//   dbg_state_o           current FSM state (IDLE=0, REQ=1, RESP=2)
module miriscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  // Attributes of the granted access, needed when the response arrives.
  logic [1:0]  r_off;
  logic [2:0]  r_size;
  logic        r_we;
  logic [31:0] r_hold;

  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_issue;
  logic        w_load_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Size/alignment decode, byte enables and replicated store data.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    case (lsu_size_i)
      3'b000, 3'b100: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << lsu_addr_i[1:0];
        w_wdata = {4{lsu_data_i[7:0]}};
      end
      3'b001, 3'b101: begin
        w_legal = ~lsu_addr_i[0];
        w_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{lsu_data_i[15:0]}};
      end
      3'b010: begin
        w_legal = (lsu_addr_i[1:0] == 2'b00);
        w_be    = 4'b1111;
        w_wdata = lsu_data_i;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // The request is presented in IDLE (new access) and REQ (awaiting grant).
  assign w_issue     = ~rst_i & lsu_req_i & w_legal & (r_state != ST_RESP);
  assign w_load_done = ~rst_i & (r_state == ST_RESP) & data_rvalid_i & ~r_we;

  // Memory-side outputs are zero whenever no request is presented.
  assign data_req_o   = w_issue;
  assign data_we_o    = w_issue ? lsu_we_i : 1'b0;
  assign data_be_o    = w_issue ? w_be : 4'b0000;
  assign data_addr_o  = w_issue ? {lsu_addr_i[31:2], 2'b00} : 32'h0;
  assign data_wdata_o = w_issue ? w_wdata : 32'h0;

  assign lsu_err_o   = ~rst_i & lsu_req_i & ~w_legal;
  assign lsu_stall_o = ~rst_i & lsu_req_i & w_legal &
                       ~((r_state == ST_RESP) & data_rvalid_i);

  // Load extraction uses the offset/size captured at grant time.
  always_comb begin
    w_byte = data_rdata_i[7:0];
    case (r_off)
      2'd0: w_byte = data_rdata_i[7:0];
      2'd1: w_byte = data_rdata_i[15:8];
      2'd2: w_byte = data_rdata_i[23:16];
      2'd3: w_byte = data_rdata_i[31:24];
      default: w_byte = data_rdata_i[7:0];
    endcase
    w_half = r_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    // r_size[2] marks the unsigned variants (LBU/LHU).
    case (r_size[1:0])
      2'b00:   w_ext = {{24{~r_size[2] & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{~r_size[2] & w_half[15]}}, w_half};
      default: w_ext = data_rdata_i;
    endcase
  end

  assign lsu_data_o  = rst_i ? 32'h0 : (w_load_done ? w_ext : r_hold);
  assign dbg_state_o = r_state;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (lsu_req_i && w_legal) begin
          w_state_next = data_gnt_i ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (data_gnt_i) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (data_rvalid_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_off   <= 2'b00;
      r_size  <= 3'b000;
      r_we    <= 1'b0;
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_issue && data_gnt_i) begin
        r_off  <= lsu_addr_i[1:0];
        r_size <= lsu_size_i;
        r_we   <= lsu_we_i;
      end
      if (w_load_done) begin
        r_hold <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Testbench for miriscv_lsu: per-cycle vector table plus delayed-handshake
// load sequences checked against an expected-data queue.
module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_size_i = 3'b0;
  logic [31:0] lsu_addr_i = 32'h0;
  logic [31:0] lsu_data_i = 32'h0;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'h0;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk_i(clk), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
    .lsu_stall_o(lsu_stall_o), .lsu_err_o(lsu_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .dbg_state_o(dbg_state_o)
  );

  typedef struct {
    logic        rst, req, we;
    logic [2:0]  size;
    logic [31:0] addr, wd;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req, e_stall, e_err, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_data;
    logic        chk_mem;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, req, we, input logic [2:0] size,
                     input logic [31:0] addr, wd, input logic gnt, rv,
                     input logic [31:0] rdata,
                     input logic e_req, e_stall, e_err, e_we,
                     input logic [3:0] e_be, input logic [31:0] e_addr,
                     e_wdata, e_data, input logic chk_mem);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.size = size; v.addr = addr;
    v.wd = wd; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.e_req = e_req; v.e_stall = e_stall; v.e_err = e_err; v.e_we = e_we;
    v.e_be = e_be; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_data = e_data;
    v.chk_mem = chk_mem;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver task: apply one cycle of inputs at the falling edge
  task automatic drive(input logic rst, req, we, input logic [2:0] size,
                       input logic [31:0] addr, wd, input logic gnt, rv,
                       input logic [31:0] rdata);
    @(negedge clk);
    rst_i = rst; lsu_req_i = req; lsu_we_i = we; lsu_size_i = size;
    lsu_addr_i = addr; lsu_data_i = wd; data_gnt_i = gnt;
    data_rvalid_i = rv; data_rdata_i = rdata;
    #1;
  endtask

  // Load word with gd grant-wait cycles and rd rvalid-wait cycles.
  task automatic lw_seq(input int gd, input int rd, input logic [31:0] addr,
                        input logic [31:0] rdata);
    int total;
    logic [31:0] exp_d;
    total = gd + rd + 2;
    exp_q.push_back(rdata);
    for (int c = 0; c < total; c++) begin
      drive(1'b0, 1'b1, 1'b0, 3'b010, addr, 32'h0, (c == gd), (c == total - 1), rdata);
      chk($sformatf("seq%0d_%0d_c%0d_req", gd, rd, c), {31'h0, data_req_o}, {31'h0, c <= gd});
      chk($sformatf("seq%0d_%0d_c%0d_stall", gd, rd, c), {31'h0, lsu_stall_o},
          {31'h0, c != total - 1});
      if (c <= gd) begin
        chk($sformatf("seq%0d_%0d_c%0d_addr", gd, rd, c), data_addr_o, {addr[31:2], 2'b00});
      end
      if (c == total - 1) begin
        exp_d = exp_q.pop_front();
        chk($sformatf("seq%0d_%0d_data", gd, rd), lsu_data_o, exp_d);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk($sformatf("seq%0d_%0d_hold", gd, rd), lsu_data_o, rdata);
    chk($sformatf("seq%0d_%0d_idle_req", gd, rd), {31'h0, data_req_o}, 32'h0);
  endtask

  initial begin
    // rst req we sz addr wd gnt rv rdata | req stall err we be addr wdata data chk
    add(1,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h0,1);
    add(1,1,0,3'd2,32'h10,32'h0,1,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h0,1);
    add(0,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h0,1);
    // LW 0x10, gnt at issue, rvalid next cycle
    add(0,1,0,3'd2,32'h10,32'h0,1,0,32'h0,           1,1,0,0,4'hF,32'h10,32'h0,32'h0,1);
    add(0,1,0,3'd2,32'h10,32'h0,0,1,32'hDEADBEEF,    0,0,0,0,4'h0,32'h00,32'h0,32'hDEADBEEF,0);
    add(0,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'hDEADBEEF,1);
    // LB / LBU 0x13
    add(0,1,0,3'd0,32'h13,32'h0,1,0,32'h0,           1,1,0,0,4'h8,32'h10,32'h0,32'hDEADBEEF,1);
    add(0,1,0,3'd0,32'h13,32'h0,0,1,32'h80123456,    0,0,0,0,4'h0,32'h00,32'h0,32'hFFFFFF80,0);
    add(0,1,0,3'd4,32'h13,32'h0,1,0,32'h0,           1,1,0,0,4'h8,32'h10,32'h0,32'hFFFFFF80,1);
    add(0,1,0,3'd4,32'h13,32'h0,0,1,32'h80123456,    0,0,0,0,4'h0,32'h00,32'h0,32'h00000080,0);
    // SH 0x22, gnt delayed 2 cycles
    add(0,1,1,3'd1,32'h22,32'hABCD,0,0,32'h0,        1,1,0,1,4'hC,32'h20,32'hABCDABCD,32'h80,1);
    add(0,1,1,3'd1,32'h22,32'hABCD,0,0,32'h0,        1,1,0,1,4'hC,32'h20,32'hABCDABCD,32'h80,1);
    add(0,1,1,3'd1,32'h22,32'hABCD,1,0,32'h0,        1,1,0,1,4'hC,32'h20,32'hABCDABCD,32'h80,1);
    add(0,1,1,3'd1,32'h22,32'hABCD,0,1,32'h55555555, 0,0,0,0,4'h0,32'h00,32'h0,32'h80,0);
    add(0,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h80,1);
    // errors: LW 0x01, LH 0x03, size 011
    add(0,1,0,3'd2,32'h01,32'h0,0,0,32'h0,           0,0,1,0,4'h0,32'h00,32'h0,32'h80,1);
    add(0,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h80,1);
    add(0,1,0,3'd1,32'h03,32'h0,0,0,32'h0,           0,0,1,0,4'h0,32'h00,32'h0,32'h80,1);
    add(0,1,0,3'd3,32'h00,32'h0,0,0,32'h0,           0,0,1,0,4'h0,32'h00,32'h0,32'h80,1);
    add(0,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h80,1);
    // reset in RESP, then a stray rvalid
    add(0,1,0,3'd2,32'h40,32'h0,1,0,32'h0,           1,1,0,0,4'hF,32'h40,32'h0,32'h80,1);
    add(1,1,0,3'd2,32'h40,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h0,1);
    add(0,0,0,3'd0,32'h00,32'h0,0,1,32'h12345678,    0,0,0,0,4'h0,32'h00,32'h0,32'h0,1);
    // back-to-back LHU 0x02, SW 0x04, LH 0x02
    add(0,1,0,3'd5,32'h02,32'h0,1,0,32'h0,           1,1,0,0,4'hC,32'h00,32'h0,32'h0,1);
    add(0,1,0,3'd5,32'h02,32'h0,0,1,32'hF00D0000,    0,0,0,0,4'h0,32'h00,32'h0,32'h0000F00D,0);
    add(0,1,1,3'd2,32'h04,32'h11223344,1,0,32'h0,    1,1,0,1,4'hF,32'h04,32'h11223344,32'h0000F00D,1);
    add(0,1,1,3'd2,32'h04,32'h11223344,0,1,32'h0,    0,0,0,0,4'h0,32'h00,32'h0,32'h0000F00D,0);
    add(0,1,0,3'd1,32'h02,32'h0,1,0,32'h0,           1,1,0,0,4'hC,32'h00,32'h0,32'h0000F00D,1);
    add(0,1,0,3'd1,32'h02,32'h0,0,1,32'hF00D0000,    0,0,0,0,4'h0,32'h00,32'h0,32'hFFFFF00D,0);
    // rvalid in IDLE and REQ ignored, then a delayed real response
    add(0,1,0,3'd2,32'h08,32'h0,0,1,32'hAAAAAAAA,    1,1,0,0,4'hF,32'h08,32'h0,32'hFFFFF00D,1);
    add(0,1,0,3'd2,32'h08,32'h0,0,1,32'hAAAAAAAA,    1,1,0,0,4'hF,32'h08,32'h0,32'hFFFFF00D,1);
    add(0,1,0,3'd2,32'h08,32'h0,1,0,32'h0,           1,1,0,0,4'hF,32'h08,32'h0,32'hFFFFF00D,1);
    add(0,1,0,3'd2,32'h08,32'h0,0,0,32'h0,           0,1,0,0,4'h0,32'h00,32'h0,32'hFFFFF00D,0);
    add(0,1,0,3'd2,32'h08,32'h0,0,1,32'h01020304,    0,0,0,0,4'h0,32'h00,32'h0,32'h01020304,0);
    add(0,0,0,3'd0,32'h00,32'h0,0,0,32'h0,           0,0,0,0,4'h0,32'h00,32'h0,32'h01020304,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].size, vecs[i].addr,
            vecs[i].wd, vecs[i].gnt, vecs[i].rv, vecs[i].rdata);
      chk($sformatf("v%0d_req", i),   {31'h0, data_req_o},  {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d_stall", i), {31'h0, lsu_stall_o}, {31'h0, vecs[i].e_stall});
      chk($sformatf("v%0d_err", i),   {31'h0, lsu_err_o},   {31'h0, vecs[i].e_err});
      chk($sformatf("v%0d_data", i),  lsu_data_o, vecs[i].e_data);
      if (vecs[i].chk_mem) begin
        chk($sformatf("v%0d_we", i),    {31'h0, data_we_o}, {31'h0, vecs[i].e_we});
        chk($sformatf("v%0d_be", i),    {28'h0, data_be_o}, {28'h0, vecs[i].e_be});
        chk($sformatf("v%0d_addr", i),  data_addr_o,  vecs[i].e_addr);
        chk($sformatf("v%0d_wdata", i), data_wdata_o, vecs[i].e_wdata);
      end
    end

    lw_seq(1, 2, 32'h0000_0100, 32'hCAFEF00D);
    lw_seq(3, 0, 32'h0000_0204, 32'h13572468);
    lw_seq(0, 3, 32'h0000_030C, 32'h8000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
